max_product_reverse_buffer: RTL

Symbol-order reversal and beta-recursion sequencer feeding the max-product symbol stage of the turbo decoder. During the forward pass it stores one record per trellis section: the alpha metrics (AlphaMetric) and the branch metrics (branch_metric). It then replays the records newest-first to the symbol stage, one section at a time. For each section it supplies the previous beta vector as old-beta, and it captures the stage's returned BetaMetric before issuing the next section.

---
 rtl/max_product_reverse_buffer_if.sv | 34 +++
 rtl/max_product_reverse_buffer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/max_product_reverse_buffer_if.sv
// Record-write, issue and beta-return signals between the forward pass,
// the reverse buffer and the max-product symbol stage.
interface max_product_reverse_buffer_if #(
  parameter int BITS           = 16,
  parameter int STATES         = 4,
  parameter int OUTPUT_SYMBOLS = 4
);
  logic                                 wr_valid;
  logic                                 wr_ready;
  logic                                 wr_last;
  logic [STATES-1:0][BITS-1:0]          wr_alpha;
  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]  wr_branch;
  logic                                 out_valid;
  logic [STATES-1:0][BITS-1:0]          out_alpha;
  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]  out_branch;
  logic [STATES-1:0][BITS-1:0]          out_old_beta;
  logic                                 beta_valid;
  logic [STATES-1:0][BITS-1:0]          beta_in;
  logic                                 busy;
  logic                                 done;
  logic                                 length_err;

  modport master (
    output wr_valid, wr_last, wr_alpha, wr_branch, beta_valid, beta_in,
    input  wr_ready, out_valid, out_alpha, out_branch, out_old_beta,
           busy, done, length_err
  );

  modport slave (
    input  wr_valid, wr_last, wr_alpha, wr_branch, beta_valid, beta_in,
    output wr_ready, out_valid, out_alpha, out_branch, out_old_beta,
           busy, done, length_err
  );
endinterface

// File: rtl/max_product_reverse_buffer.sv
// Stores forward-pass trellis records, then replays them newest-first to the
// symbol stage while chaining each returned beta vector into the next issue.
module max_product_reverse_buffer #(
  parameter int              BITS           = 16,
  parameter int              STATES         = 4,
  parameter int              OUTPUT_SYMBOLS = 4,
  parameter int              BLOCK_LEN      = 64,
  parameter logic [BITS-1:0] ONE            = 16'h3C00,
  parameter bit              TERMINATED     = 1'b1
) (
  input logic                          clk,
  input logic                          rstn,
  max_product_reverse_buffer_if.slave  bus
);
  localparam int AW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int AB = STATES * BITS;
  localparam int RW = (STATES + OUTPUT_SYMBOLS) * BITS;

  typedef logic [STATES-1:0][BITS-1:0]         vec_t;
  typedef logic [OUTPUT_SYMBOLS-1:0][BITS-1:0] br_t;
  typedef enum logic [2:0] {FILL, ISSUE, PRESENT, WAIT, DONE} state_t;

  function automatic vec_t init_vec();
    vec_t v;
    v = '0;
    for (int unsigned s = 0; s < STATES; s++)
      if (TERMINATED == 1'b0 || s == 0) v[s] = ONE;
    return v;
  endfunction

  localparam vec_t BETA_INIT = init_vec();

  logic [RW-1:0] mem [BLOCK_LEN];
  logic [RW-1:0] rd_rec;
  logic          wr_en;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  vec_t          old_beta_q, old_beta_d;
  vec_t          out_alpha_q, out_alpha_d;
  br_t           out_branch_q, out_branch_d;
  vec_t          out_old_beta_q, out_old_beta_d;
  logic          out_valid_q, out_valid_d;
  logic          done_q, done_d;
  logic          length_err_q, length_err_d;
  logic          busy_q, busy_d;
  logic          wr_ready_q, wr_ready_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {bus.wr_branch, bus.wr_alpha};
  end

  assign rd_rec = mem[rd_ptr_q];

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    old_beta_d     = old_beta_q;
    out_alpha_d    = out_alpha_q;
    out_branch_d   = out_branch_q;
    out_old_beta_d = out_old_beta_q;
    out_valid_d    = 1'b0;
    done_d         = 1'b0;
    length_err_d   = 1'b0;
    wr_en          = 1'b0;
    unique case (state_q)
      FILL: begin
        if (bus.wr_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (bus.wr_last || wr_ptr_q == AW'(BLOCK_LEN - 1)) begin
            rd_ptr_d     = wr_ptr_q;
            old_beta_d   = BETA_INIT;
            length_err_d = ~bus.wr_last;
            state_d      = ISSUE;
          end
        end
      end
      // The output registers double as the memory read register, so the
      // section is visible together with out_valid during PRESENT.
      ISSUE: begin
        out_alpha_d    = rd_rec[AB-1:0];
        out_branch_d   = rd_rec[RW-1:AB];
        out_old_beta_d = old_beta_q;
        out_valid_d    = 1'b1;
        state_d        = PRESENT;
      end
      PRESENT: state_d = WAIT;
      WAIT: begin
        if (bus.beta_valid) begin
          old_beta_d = bus.beta_in;
          if (rd_ptr_q == '0) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            rd_ptr_d = rd_ptr_q - 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      DONE: begin
        wr_ptr_d = '0;
        state_d  = FILL;
      end
      default: state_d = FILL;
    endcase
    busy_d     = (state_d != FILL);
    wr_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= FILL;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      old_beta_q     <= BETA_INIT;
      out_alpha_q    <= '0;
      out_branch_q   <= '0;
      out_old_beta_q <= BETA_INIT;
      out_valid_q    <= 1'b0;
      done_q         <= 1'b0;
      length_err_q   <= 1'b0;
      busy_q         <= 1'b0;
      wr_ready_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      old_beta_q     <= old_beta_d;
      out_alpha_q    <= out_alpha_d;
      out_branch_q   <= out_branch_d;
      out_old_beta_q <= out_old_beta_d;
      out_valid_q    <= out_valid_d;
      done_q         <= done_d;
      length_err_q   <= length_err_d;
      busy_q         <= busy_d;
      wr_ready_q     <= wr_ready_d;
    end
  end

  assign bus.wr_ready     = wr_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_alpha    = out_alpha_q;
  assign bus.out_branch   = out_branch_q;
  assign bus.out_old_beta = out_old_beta_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.length_err   = length_err_q;
endmodule
